// File: rtl/mac_sequencer_pkg.sv
// Shared convolver definitions: MAC FSM encoding, accumulator width and saturation limits.
// Pure declarations; no logic, no latency, no flow control.
package mac_sequencer_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    // The accumulator is sized so that KERNEL_SIZE full-scale products can never wrap.
    function automatic int acc_width(input int data_width, input int kernel_size);
        return data_width + $clog2(kernel_size);
    endfunction

    function automatic longint sat_hi(input int data_width);
        return (longint'(1) <<< (data_width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int data_width);
        return -(longint'(1) <<< (data_width - 1));
    endfunction

endpackage

// File: rtl/mult.sv
// Signed fixed-point multiplier: keeps the DATA_WIDTH bits above FRAC_BIT (floor, no saturation).
// Latency: combinational. Backpressure: none.
module mult #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BIT   = 8
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] p_o
);

    logic signed [2*DATA_WIDTH-1:0] prod_full;

    assign prod_full = a_i * b_i;
    // Arithmetic shift then truncate gives bits [DATA_WIDTH+FRAC_BIT-1:FRAC_BIT].
    assign p_o       = DATA_WIDTH'(prod_full >>> FRAC_BIT);

endmodule

// File: rtl/mac_sequencer.sv
// Kernel MAC: accumulates KERNEL_SIZE pixel*weight pairs and emits one saturated sum.
// Latency: result valid 1 cycle after the last pair. Backpressure: in_ready drops while a result waits on out_ready.
module mac_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pixel,
    input  logic [DATA_WIDTH-1:0] weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    import mac_sequencer_pkg::*;

    localparam int CNT_W     = $clog2(KERNEL_SIZE);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, KERNEL_SIZE);
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_hi(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_lo(DATA_WIDTH));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_SIZE - 1);

    state_e                        state_q, state_d;
    logic        [CNT_W-1:0]       count_q, count_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [DATA_WIDTH-1:0]  out_data_q, out_data_d;

    logic signed [DATA_WIDTH-1:0]  prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc_base;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic        [DATA_WIDTH-1:0]  sum_sat;

    mult #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BIT   (FRAC_BIT)
    ) u_mult (
        .a_i (pixel),
        .b_i (weight),
        .p_o (prod)
    );

    assign prod_ext = {{CNT_W{prod[DATA_WIDTH-1]}}, prod};
    // First pair of a kernel loads rather than adds, so no stale sum can leak in.
    assign acc_base = (count_q == '0) ? '0 : acc_q;
    assign sum      = acc_base + prod_ext;

    always_comb begin
        sum_sat = DATA_WIDTH'(sum);
        if (sum > SAT_HI) begin
            sum_sat = DATA_WIDTH'(SAT_HI);
        end else if (sum < SAT_LO) begin
            sum_sat = DATA_WIDTH'(SAT_LO);
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        if (clear) begin
            state_d = ST_ACCUM;
            count_d = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum;
                        if (count_q == CNT_LAST) begin
                            out_data_d = sum_sat;
                            count_d    = '0;
                            state_d    = ST_DONE;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign busy      = (count_q != '0) || (state_q == ST_DONE);

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the fixed-point word width of pixel, weight and result.
REQ-002 SHALL have parameter FRAC_BIT, default 8, the number of fractional bits in every word.
REQ-003 SHALL have parameter KERNEL_SIZE, default 9, the number of pixel/weight pairs per result (legal range 2..256).
REQ-004 Port list: clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clear  in  1  synchronous abort of the current kernel.
REQ-007 in_valid  in  1  pixel/weight pair valid.
REQ-008 in_ready  out  1  block can accept a pair.
REQ-009 pixel  in  DATA_WIDTH  signed Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT operand.
REQ-010 weight  in  DATA_WIDTH  signed operand, same format.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data  out  DATA_WIDTH  signed saturated kernel sum, same format.
REQ-014 busy  out  1  kernel partially accumulated or result pending.

Function
REQ-015 Pair transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; result transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 Per pair, product SHALL be the full 2*DATA_WIDTH signed product, bits [DATA_WIDTH+FRAC_BIT-1:FRAC_BIT] kept: floor rounding, no saturation on the product.
REQ-017 Accumulator SHALL be signed, ACC_WIDTH = DATA_WIDTH + ceil(log2(KERNEL_SIZE)) bits, with products sign-extended; it can never overflow.
REQ-018 FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-019 In ACCUM, on a transfer with count==0 the accumulator SHALL load the product (no stale sum); otherwise it SHALL add the product; count increments.
REQ-020 On the transfer with count==KERNEL_SIZE-1: out_data <= saturate(acc+product) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], count <= 0, state <= DONE; out_valid rises the next cycle (latency 1 cycle after last pair).
REQ-021 In DONE, out_data and out_valid SHALL hold stable until out_ready; on the result transfer state <= ACCUM; no pair is accepted in that same cycle.
REQ-022 busy SHALL be 1 when count!=0 or state==DONE, else 0.
REQ-023 clear SHALL force count=0, state=ACCUM, out_valid=0, discarding any partial sum or pending result; clear overrides a simultaneous pair or result transfer, and the pair presented in that cycle is not consumed.
REQ-024 in_valid while in DONE SHALL be ignored (pair held by upstream via in_ready=0).
REQ-025 out_data SHALL be registered; no combinational path from pixel/weight to out_data.

Reset
REQ-026 reset SHALL take priority over clear and all transfers.
REQ-027 After reset: state=ACCUM, count=0, accumulator=0, out_data=0, out_valid=0, in_ready=1, busy=0.
REQ-028 Reset asserted mid-kernel or in DONE SHALL discard all progress; the next result uses only pairs accepted after reset.

Structure
REQ-029 The FSM state encoding and the ACC_WIDTH/saturation-limit computation SHALL live in the shared convolver package.
REQ-030 The product SHALL come from one instance of the existing fixed-point multiplier sub-module mult (DATA_WIDTH, FRAC_BIT passed through); no second multiplier.

Verification (DATA_WIDTH=16, FRAC_BIT=8, KERNEL_SIZE=9)
REQ-031 9 pairs pixel=0x0200, weight=0x0180, back-to-back, out_ready=1 -> out_data=0x1B00 (27.0), out_valid for exactly 1 cycle, 1 cycle after 9th pair.
REQ-032 9 pairs 0x7FFF*0x0100 -> 0x7FFF; 9 pairs 0x8000*0x0100 -> 0x8000 (saturation both ends).
REQ-033 pixel=0xFFFF, weight=0x0080, other 8 pairs 0 -> out_data=0xFFFF (floor truncation).
REQ-034 out_ready low 3 cycles after result -> out_data stable, in_ready=0, busy=1; 10th pair held then accepted after the handshake.
REQ-035 4 pairs, then clear together with a 5th pair, then 9 pairs of 0x0100*0x0100 -> out_data=0x0900; 5th pair not counted.
REQ-036 reset in DONE with out_ready=0 -> next cycle out_valid=0, busy=0, in_ready=1, out_data=0.
